// File: rtl/apb_master_ctrl.sv
// APB master stage of the AXI-to-APB bridge.
// Accepts single/multi-beat read and write requests from the protocol handler,
// buffers write data in a small FIFO, and drives each beat as one APB3
// transfer to one of two decoded slave windows.
module apb_master_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_trans_i,
  input  logic                  rd_trans_i,
  input  logic [ADDR_WIDTH-1:0] trans_addr_i,
  input  logic [3:0]            burst_len_i,
  input  logic [DATA_WIDTH-1:0] trans_data_i,
  input  logic                  fifo_wren_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  trans_done_o,
  output logic                  trans_error_o,
  output logic                  fifo_full_o,
  output logic                  fifo_ovf_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [1:0]            psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAGE_W = ADDR_WIDTH - 12;
  localparam logic [PAGE_W-1:0] SLV0_PAGE = PAGE_W'(32'h0001_F);
  localparam logic [PAGE_W-1:0] SLV1_PAGE = PAGE_W'(32'h0002_F);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Transaction context latched at request time
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  is_read_q;
  logic [3:0]            len_q;
  logic [3:0]            beat_cnt_q;
  logic                  err_acc_q;

  // Registered handler-side status
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  done_q;
  logic                  error_q;

  // Write-data FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic [CNT_W-1:0]      fifo_cnt_nxt;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic                  ovf_q;

  // Beat bookkeeping
  logic [1:0]            sel;
  logic                  beat_done;
  logic                  beat_err;
  logic [DATA_WIDTH-1:0] beat_rdata;
  logic                  last_beat;
  logic                  req;

  assign req        = rd_trans_i | wr_trans_i;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full_o = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_ovf_o = ovf_q;

  // Slave decode on the 4 KB page of the current beat address.
  assign sel[0] = (addr_q[ADDR_WIDTH-1:12] == SLV0_PAGE);
  assign sel[1] = (addr_q[ADDR_WIDTH-1:12] == SLV1_PAGE);

  // An undecoded beat completes in SETUP without ever raising psel.
  assign beat_done  = ((state == SETUP) && (sel == 2'b00)) ||
                      ((state == ACCESS) && pready_i);
  assign beat_err   = (sel == 2'b00) ? 1'b1 : pslverr_i;
  assign beat_rdata = (sel == 2'b00) ? '0 : prdata_i;
  assign last_beat  = (beat_cnt_q == len_q);

  assign push = fifo_wren_i && !fifo_full_o;
  assign pop  = beat_done && !is_read_q;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    fifo_cnt_nxt = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + 1'b1;
      2'b01:   fifo_cnt_nxt = fifo_cnt - 1'b1;
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt_nxt;
      if (fifo_wren_i && fifo_full_o) ovf_q <= 1'b1;
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; pointers and count define which entries are valid.
    if (push) fifo_mem[wr_ptr] <= trans_data_i;
  end

  // State register; reset drops psel/penable immediately through the output decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_trans_i)      state_nxt = SETUP;
        else if (wr_trans_i) state_nxt = fifo_empty ? WAIT_DATA : SETUP;
      end
      WAIT_DATA: begin
        if (!fifo_empty) state_nxt = SETUP;
      end
      SETUP, ACCESS: begin
        if ((state == SETUP) && (sel != 2'b00)) begin
          state_nxt = ACCESS;
        end else if (beat_done) begin
          if (last_beat)                state_nxt = DONE;
          else if (is_read_q)           state_nxt = SETUP;
          else if (fifo_cnt_nxt == '0)  state_nxt = WAIT_DATA;
          else                          state_nxt = SETUP;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APB output decode; address, select and write data are stable across SETUP and ACCESS.
  always_comb begin
    paddr_o   = '0;
    psel_o    = 2'b00;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    pwdata_o  = '0;
    if ((state == SETUP) || (state == ACCESS)) begin
      paddr_o   = addr_q;
      psel_o    = sel;
      penable_o = (state == ACCESS);
      pwrite_o  = !is_read_q;
      pwdata_o  = is_read_q ? '0 : fifo_mem[rd_ptr];
    end
  end

  // Transaction context, beat advance and registered completion status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      is_read_q  <= 1'b0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      err_acc_q  <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if ((state == IDLE) && req) begin
        addr_q     <= trans_addr_i;
        is_read_q  <= rd_trans_i;
        len_q      <= burst_len_i;
        beat_cnt_q <= '0;
        err_acc_q  <= 1'b0;
      end
      if (beat_done) begin
        if (!last_beat) begin
          beat_cnt_q   <= beat_cnt_q + 1'b1;
          // Increment wraps within the 4 KB page; upper bits stay fixed.
          addr_q[11:0] <= addr_q[11:0] + 12'd4;
        end
        if (is_read_q) begin
          done_q  <= 1'b1;
          error_q <= beat_err;
          rdata_q <= beat_rdata;
        end else begin
          err_acc_q <= err_acc_q | beat_err;
          if (last_beat) begin
            done_q  <= 1'b1;
            error_q <= err_acc_q | beat_err;
          end
        end
      end
    end
  end

  assign read_data_o   = rdata_q;
  assign trans_done_o  = done_q;
  assign trans_error_o = error_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl.
module tb_apb_master_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_trans_i;
  logic        rd_trans_i;
  logic [31:0] trans_addr_i;
  logic [3:0]  burst_len_i;
  logic [31:0] trans_data_i;
  logic        fifo_wren_i;
  logic [31:0] read_data_o;
  logic        trans_done_o;
  logic        trans_error_o;
  logic        fifo_full_o;
  logic        fifo_ovf_o;
  logic [31:0] paddr_o;
  logic [1:0]  psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  apb_master_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_trans_i    (wr_trans_i),
    .rd_trans_i    (rd_trans_i),
    .trans_addr_i  (trans_addr_i),
    .burst_len_i   (burst_len_i),
    .trans_data_i  (trans_data_i),
    .fifo_wren_i   (fifo_wren_i),
    .read_data_o   (read_data_o),
    .trans_done_o  (trans_done_o),
    .trans_error_o (trans_error_o),
    .fifo_full_o   (fifo_full_o),
    .fifo_ovf_o    (fifo_ovf_o),
    .paddr_o       (paddr_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .pwdata_o      (pwdata_o),
    .prdata_i      (prdata_i),
    .pready_i      (pready_i),
    .pslverr_i     (pslverr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observations gathered by watch()
  int          psel_cyc;
  int          en_cyc;
  int          held_bad;
  logic [31:0] setup_addr[$];
  logic [31:0] setup_wdata[$];
  logic [1:0]  setup_sel[$];
  logic        setup_wr[$];
  logic [31:0] done_data[$];
  logic        done_err[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_psel"},    32'(psel_o), 32'd0);
    check({pfx, "_penable"}, 32'(penable_o), 32'd0);
    check({pfx, "_paddr"},   paddr_o, 32'd0);
    check({pfx, "_pwrite"},  32'(pwrite_o), 32'd0);
    check({pfx, "_pwdata"},  pwdata_o, 32'd0);
    check({pfx, "_done"},    32'(trans_done_o), 32'd0);
    check({pfx, "_error"},   32'(trans_error_o), 32'd0);
    check({pfx, "_rdata"},   read_data_o, 32'd0);
    check({pfx, "_full"},    32'(fifo_full_o), 32'd0);
    check({pfx, "_ovf"},     32'(fifo_ovf_o), 32'd0);
  endtask

  // Acts as the APB slave for n cycles: beat 0 inserts `waits` wait states,
  // beat `err_beat` answers with pslverr; prdata is 0x1111_0000 + beat index.
  task automatic watch(input int n, input int waits, input int err_beat);
    int wait_left;
    int acc_beat;
    wait_left = waits;
    acc_beat  = 0;
    psel_cyc  = 0;
    en_cyc    = 0;
    held_bad  = 0;
    setup_addr.delete();
    setup_wdata.delete();
    setup_sel.delete();
    setup_wr.delete();
    done_data.delete();
    done_err.delete();
    for (int i = 0; i < n; i++) begin
      if (trans_done_o) begin
        done_data.push_back(read_data_o);
        done_err.push_back(trans_error_o);
      end
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      if (psel_o != 2'b00) psel_cyc++;
      if (psel_o != 2'b00 && !penable_o) begin
        setup_addr.push_back(paddr_o);
        setup_wdata.push_back(pwdata_o);
        setup_sel.push_back(psel_o);
        setup_wr.push_back(pwrite_o);
      end
      if (penable_o) begin
        en_cyc++;
        if (setup_addr.size() == 0 || paddr_o !== setup_addr[$] || psel_o !== setup_sel[$])
          held_bad++;
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          pready_i  = 1'b1;
          pslverr_i = (acc_beat == err_beat);
          prdata_i  = 32'h1111_0000 + 32'(acc_beat);
          acc_beat++;
        end
      end
      tick();
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
  endtask

  task automatic request(input logic rd, input logic wr, input logic [31:0] addr, input logic [3:0] len);
    rd_trans_i   = rd;
    wr_trans_i   = wr;
    trans_addr_i = addr;
    burst_len_i  = len;
    tick();
    rd_trans_i = 1'b0;
    wr_trans_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    wr_trans_i   = 1'b0;
    rd_trans_i   = 1'b0;
    trans_addr_i = '0;
    burst_len_i  = '0;
    trans_data_i = '0;
    fifo_wren_i  = 1'b0;
    prdata_i     = '0;
    pready_i     = 1'b0;
    pslverr_i    = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single read, zero wait states.
    request(1'b1, 1'b0, 32'h0001_F004, 4'd0);
    watch(6, 0, -1);
    check("rd1_psel_cycles", 32'(psel_cyc), 32'd2);
    check("rd1_setup_sel",   32'(setup_sel[0]), 32'd1);
    check("rd1_setup_addr",  setup_addr[0], 32'h0001_F004);
    check("rd1_pwrite",      32'(setup_wr[0]), 32'd0);
    check("rd1_done_cnt",    32'(done_data.size()), 32'd1);
    check("rd1_data",        done_data[0], 32'h1111_0000);
    check("rd1_err",         32'(done_err[0]), 32'd0);

    // Four-beat write burst wrapping within the 4 KB page.
    for (int i = 0; i < 4; i++) begin
      fifo_wren_i  = 1'b1;
      trans_data_i = 32'hA000_0000 + 32'(i);
      tick();
    end
    fifo_wren_i = 1'b0;
    request(1'b0, 1'b1, 32'h0002_FFF8, 4'd3);
    watch(12, 0, -1);
    check("wr4_psel_cycles", 32'(psel_cyc), 32'd8);
    check("wr4_setups",      32'(setup_addr.size()), 32'd4);
    check("wr4_addr0",       setup_addr[0], 32'h0002_FFF8);
    check("wr4_addr1",       setup_addr[1], 32'h0002_FFFC);
    check("wr4_addr2",       setup_addr[2], 32'h0002_F000);
    check("wr4_addr3",       setup_addr[3], 32'h0002_F004);
    check("wr4_sel",         32'(setup_sel[2]), 32'd2);
    check("wr4_pwrite",      32'(setup_wr[0]), 32'd1);
    check("wr4_wdata0",      setup_wdata[0], 32'hA000_0000);
    check("wr4_wdata3",      setup_wdata[3], 32'hA000_0003);
    check("wr4_done_cnt",    32'(done_err.size()), 32'd1);
    check("wr4_err",         32'(done_err[0]), 32'd0);

    // Write with an empty FIFO waits until data arrives.
    request(1'b0, 1'b1, 32'h0001_F010, 4'd0);
    for (int i = 0; i < 4; i++) begin
      check("wait_psel", 32'(psel_o), 32'd0);
      tick();
    end
    fifo_wren_i  = 1'b1;
    trans_data_i = 32'hC3C3_C3C3;
    check("wait_psel_last", 32'(psel_o), 32'd0);
    tick();
    fifo_wren_i = 1'b0;
    watch(5, 0, -1);
    check("wait_psel_cycles", 32'(psel_cyc), 32'd2);
    check("wait_wdata",       setup_wdata[0], 32'hC3C3_C3C3);
    check("wait_done_cnt",    32'(done_err.size()), 32'd1);

    // Undecoded read: no APB transfer, error completion with zero data.
    prdata_i = 32'hFFFF_FFFF;
    request(1'b1, 1'b0, 32'h0003_0000, 4'd0);
    watch(5, 0, -1);
    check("undec_psel_cycles", 32'(psel_cyc), 32'd0);
    check("undec_done_cnt",    32'(done_data.size()), 32'd1);
    check("undec_err",         32'(done_err[0]), 32'd1);
    check("undec_data",        done_data[0], 32'd0);

    // Two-beat read: three wait states on beat 0, slave error on beat 1.
    request(1'b1, 1'b0, 32'h0001_F040, 4'd1);
    watch(12, 3, 1);
    check("rdw_en_cycles",   32'(en_cyc), 32'd5);
    check("rdw_psel_cycles", 32'(psel_cyc), 32'd7);
    check("rdw_held",        32'(held_bad), 32'd0);
    check("rdw_addr1",       setup_addr[1], 32'h0001_F044);
    check("rdw_done_cnt",    32'(done_err.size()), 32'd2);
    check("rdw_err0",        32'(done_err[0]), 32'd0);
    check("rdw_err1",        32'(done_err[1]), 32'd1);
    check("rdw_data0",       done_data[0], 32'h1111_0000);
    check("rdw_data1",       done_data[1], 32'h1111_0001);

    // Simultaneous requests: the read wins (FIFO is empty, so a write would stall).
    request(1'b1, 1'b1, 32'h0001_F020, 4'd0);
    watch(6, 0, -1);
    check("both_pwrite",   32'(setup_wr[0]), 32'd0);
    check("both_done_cnt", 32'(done_data.size()), 32'd1);
    check("both_data",     done_data[0], 32'h1111_0000);

    // Fill the FIFO, then overflow it.
    for (int i = 0; i < 16; i++) begin
      check("fill_not_full", 32'(fifo_full_o), 32'd0);
      fifo_wren_i  = 1'b1;
      trans_data_i = 32'(i);
      tick();
    end
    fifo_wren_i = 1'b0;
    check("fill_full",   32'(fifo_full_o), 32'd1);
    check("fill_no_ovf", 32'(fifo_ovf_o), 32'd0);
    fifo_wren_i = 1'b1;
    tick();
    fifo_wren_i = 1'b0;
    check("ovf_full", 32'(fifo_full_o), 32'd1);
    check("ovf_set",  32'(fifo_ovf_o), 32'd1);
    tick();
    check("ovf_sticky", 32'(fifo_ovf_o), 32'd1);

    // Reset asserted mid-ACCESS clears everything immediately.
    request(1'b0, 1'b1, 32'h0002_F000, 4'd0);
    check("abort_setup_sel", 32'(psel_o), 32'd2);
    check("abort_setup_wd",  pwdata_o, 32'd0);
    tick();
    check("abort_penable", 32'(penable_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_psel", 32'(psel_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
